cursor_box_controller: RTL and testbench
========================================

Name: cursor_box_controller

Overview:
- Sits between the debouncers and color_controller in the VGA top level.
- Turns debounced U/D/L/R/C button levels into a clamped on-screen box position and a 3-bit colour index.
- Position updates only on a once-per-frame tick, so the box never tears mid-frame.
- Holding a direction button gives typematic auto-repeat: first step, then a delay, then repeated steps.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BOX_SIZE, 32, box edge length in pixels
- STEP, 8, pixels moved per step
- HOLD_FRAMES, 20, frame ticks from the first step to the first repeat step
- REPEAT_FRAMES, 4, frame ticks between repeat steps
- X_INIT, 304, reset value of box_x
- Y_INIT, 224, reset value of box_y

Ports:
- clk  in  1  pixel clock (25 MHz); single clock domain
- reset  in  1  asynchronous, active-low; all state cleared while low
- frame_tick  in  1  one-clk pulse per frame (start of vertical blank)
- B_U  in  1  debounced Up level, 1 = pressed
- B_D  in  1  debounced Down level
- B_L  in  1  debounced Left level
- B_R  in  1  debounced Right level
- B_C  in  1  debounced Centre level
- box_x  out  10  left column of box, range 0..H_ACTIVE-BOX_SIZE
- box_y  out  10  top row of box, range 0..V_ACTIVE-BOX_SIZE
- color_sel  out  3  colour index for color_controller
- at_edge  out  1  1 when box_x or box_y sits at a limit (0 or max)

Behaviour:
- Reset values: box_x=X_INIT, box_y=Y_INIT, color_sel=0, at_edge=0, FSM=IDLE, counters=0.
- Input sync: all five buttons pass through a 2-flop synchroniser. dir = {U,D,L,R} after sync.
- Opposite pair pressed together (U&D, or L&R) cancels that axis only. The other axis still moves.
- Effective dir is dir after cancellation.
- FSM states:
  - IDLE: eff dir==0. Nonzero -> ARM.
  - ARM: waits for frame_tick. On frame_tick: apply one step, clear cnt, -> DELAY.
  - DELAY: cnt++ on each frame_tick. On the tick where cnt reaches HOLD_FRAMES: apply step, clear cnt, -> REPEAT.
  - REPEAT: cnt++ on each frame_tick. On the tick where cnt reaches REPEAT_FRAMES: apply step, clear cnt.
  - From any state: eff dir==0 -> IDLE on the next clk.
  - From any state: eff dir changes to a different nonzero value -> ARM, cnt cleared.
- Step timing: if the first step occurs on tick T0, later steps occur on T0+20, T0+24, T0+28, ... (defaults).
- Step arithmetic, done in 11 bits, then saturated:
  - right: x = min(x+STEP, H_ACTIVE-BOX_SIZE)
  - left: x = (x<STEP) ? 0 : x-STEP
  - Up and down work the same way on y with V_ACTIVE.
  - Diagonals move both axes in the same step.
- Position registers change only on a clk where frame_tick=1.
- at_edge is registered and reflects the updated position in the same cycle box_x/box_y update.
- Centre: a rising edge of synced B_C increments color_sel mod 8 (7 -> 0), 1 clk after the edge is detected. It is not frame-gated and has no auto-repeat. Holding B_C gives exactly one increment.
- A frame_tick arriving in the same clk as a direction change is not a step. The FSM takes the transition (-> ARM) instead.
- Reset asserted mid-hold restores all reset values immediately, without waiting for clk. After release, a still-held button is treated as a new press: IDLE -> ARM -> step on the next frame_tick.
- Total input latency: button edge -> FSM sees it after 2 clk (synchroniser) -> first move on the next frame_tick.

Test Plan:
- Reset low, then release with no buttons pressed, 5 frame_ticks -> box_x=304, box_y=224, color_sel=0, at_edge=0 throughout.
- Hold B_R for 30 frame_ticks, release -> box_x=312 at tick 1, 320 at tick 21, 328 at tick 25, 336 at tick 29; no further change after release.
- Tap B_L 40 times (each tap spanning 1 frame_tick) from X_INIT -> box_x decreases 8 per tap, holds at 0 from tap 38 onward, at_edge=1 once box_x=0.
- Hold B_U and B_D together while holding B_R, for 1 frame_tick -> box_y unchanged at 224, box_x=312.
- Hold B_C across 3 frame_ticks, then give 8 more distinct presses -> color_sel=1 after the hold, and color_sel=1 again after the 8 presses (wraps through 7 -> 0).
- Hold B_D; at tick 10 of DELAY pulse reset low for 3 clk; keep holding -> box_y=224 after reset, 232 on the first frame_tick after release, next step 20 ticks later.

Source files
------------

// File: rtl/cursor_box_controller.sv
// cursor_box_controller
// Converts debounced U/D/L/R/C button levels into a clamped box position
// and a 3-bit colour index. Movement is frame-gated with typematic
// auto-repeat; the centre button steps the colour index once per press.
module cursor_box_controller #(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int BOX_SIZE      = 32,
    parameter int STEP          = 8,
    parameter int HOLD_FRAMES   = 20,
    parameter int REPEAT_FRAMES = 4,
    parameter int X_INIT        = 304,
    parameter int Y_INIT        = 224
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       B_U,
    input  logic       B_D,
    input  logic       B_L,
    input  logic       B_R,
    input  logic       B_C,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic [2:0] color_sel,
    output logic       at_edge
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_DELAY  = 2'd2;
    localparam logic [1:0] S_REPEAT = 2'd3;

    localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [9:0]  X_RST   = 10'(X_INIT);
    localparam logic [9:0]  Y_RST   = 10'(Y_INIT);
    localparam logic [15:0] HOLD_C  = 16'(HOLD_FRAMES);
    localparam logic [15:0] REP_C   = 16'(REPEAT_FRAMES);

    logic [4:0]  r_sync1;
    logic [4:0]  r_sync2;
    logic [3:0]  r_dir;
    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [9:0]  r_box_x;
    logic [9:0]  r_box_y;
    logic        r_at_edge;
    logic [2:0]  r_color;
    logic        r_c_prev;

    logic [3:0]  w_dir;
    logic [3:0]  w_eff;
    logic        w_c;
    logic        w_c_rise;
    logic        w_dir_same;
    logic [15:0] w_cnt_next;
    logic        w_step;
    logic [10:0] w_x_ext;
    logic [10:0] w_y_ext;
    logic [10:0] w_next_x;
    logic [10:0] w_next_y;

    // Two-flop synchroniser for all five buttons, order {U,D,L,R,C}
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 5'd0;
            r_sync2 <= 5'd0;
        end else begin
            r_sync1 <= {B_U, B_D, B_L, B_R, B_C};
            r_sync2 <= r_sync1;
        end
    end

    assign w_dir      = r_sync2[4:1];
    assign w_c        = r_sync2[0];
    assign w_c_rise   = w_c & ~r_c_prev;
    assign w_cnt_next = r_cnt + 16'd1;
    assign w_x_ext    = {1'b0, r_box_x};
    assign w_y_ext    = {1'b0, r_box_y};
    assign w_dir_same = (w_eff == r_dir);

    // Opposite buttons on one axis cancel only that axis
    always_comb begin
        w_eff[3:2] = (w_dir[3] & w_dir[2]) ? 2'b00 : w_dir[3:2];
        w_eff[1:0] = (w_dir[1] & w_dir[0]) ? 2'b00 : w_dir[1:0];
    end

    // A step happens only on a frame tick with an unchanged, nonzero direction
    always_comb begin
        w_step = 1'b0;
        if (frame_tick && (w_eff != 4'd0) && w_dir_same) begin
            case (r_state)
                S_ARM:    w_step = 1'b1;
                S_DELAY:  w_step = (w_cnt_next == HOLD_C);
                S_REPEAT: w_step = (w_cnt_next == REP_C);
                default:  w_step = 1'b0;
            endcase
        end
    end

    // Typematic FSM: first step, hold delay, then periodic repeat steps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_dir   <= 4'd0;
        end else begin
            r_dir <= w_eff;
            if (w_eff == 4'd0) begin
                r_state <= S_IDLE;
                r_cnt   <= 16'd0;
            end else if (!w_dir_same) begin
                r_state <= S_ARM;
                r_cnt   <= 16'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_ARM;
                        r_cnt   <= 16'd0;
                    end
                    S_ARM: begin
                        if (frame_tick) begin
                            r_state <= S_DELAY;
                            r_cnt   <= 16'd0;
                        end
                    end
                    S_DELAY: begin
                        if (frame_tick) begin
                            if (w_step) begin
                                r_state <= S_REPEAT;
                                r_cnt   <= 16'd0;
                            end else begin
                                r_cnt <= w_cnt_next;
                            end
                        end
                    end
                    default: begin
                        if (frame_tick) begin
                            r_cnt <= w_step ? 16'd0 : w_cnt_next;
                        end
                    end
                endcase
            end
        end
    end

    // Saturating 11-bit step arithmetic; diagonals move both axes at once
    always_comb begin
        w_next_x = w_x_ext;
        w_next_y = w_y_ext;
        if (w_eff[0]) begin
            w_next_x = ((w_x_ext + STEP_W) > X_MAX) ? X_MAX : (w_x_ext + STEP_W);
        end else if (w_eff[1]) begin
            w_next_x = (w_x_ext < STEP_W) ? 11'd0 : (w_x_ext - STEP_W);
        end
        if (w_eff[2]) begin
            w_next_y = ((w_y_ext + STEP_W) > Y_MAX) ? Y_MAX : (w_y_ext + STEP_W);
        end else if (w_eff[3]) begin
            w_next_y = (w_y_ext < STEP_W) ? 11'd0 : (w_y_ext - STEP_W);
        end
    end

    // Position and edge flag update together, only on a stepping frame tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_box_x   <= X_RST;
            r_box_y   <= Y_RST;
            r_at_edge <= 1'b0;
        end else if (w_step) begin
            r_box_x   <= w_next_x[9:0];
            r_box_y   <= w_next_y[9:0];
            r_at_edge <= (w_next_x == 11'd0) || (w_next_x == X_MAX) ||
                         (w_next_y == 11'd0) || (w_next_y == Y_MAX);
        end
    end

    // Colour index advances once per rising edge of the synced centre button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_prev <= 1'b0;
            r_color  <= 3'd0;
        end else begin
            r_c_prev <= w_c;
            if (w_c_rise) begin
                r_color <= r_color + 3'd1;
            end
        end
    end

    assign box_x     = r_box_x;
    assign box_y     = r_box_y;
    assign color_sel = r_color;
    assign at_edge   = r_at_edge;

endmodule

// File: tb/tb_cursor_box_controller.sv
// tb_cursor_box_controller
// Directed self-checking bench for cursor_box_controller with
// hand-computed expected positions, edge flags and colour indices.
module tb_cursor_box_controller;

   logic       clk;
   logic       reset;
   logic       frame_tick;
   logic       bU, bD, bL, bR, bC;
   logic [9:0] boxX;
   logic [9:0] boxY;
   logic [2:0] colorSel;
   logic       atEdge;

   int checkCount = 0;
   int errorCount = 0;

   cursor_box_controller dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .B_U        (bU),
      .B_D        (bD),
      .B_L        (bL),
      .B_R        (bR),
      .B_C        (bC),
      .box_x      (boxX),
      .box_y      (boxY),
      .color_sel  (colorSel),
      .at_edge    (atEdge)
   );

   // 25 MHz-style free-running clock
   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   // Compare one observed value against its expected value and count it
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive all five button levels on a falling edge
   task automatic applyStimulus(input logic u, input logic d, input logic l,
                                input logic r, input logic c);
      @(negedge clk);
      bU = u; bD = d; bL = l; bR = r; bC = c;
   endtask

   task automatic waitClocks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // One-clock frame tick; returns on the falling edge after it was sampled
   task automatic frameTick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic applyReset();
      @(negedge clk);
      reset = 1'b0;
      waitClocks(3);
      reset = 1'b1;
      waitClocks(2);
   endtask

   initial begin
      int expX;
      int expY;
      int expC;
      reset = 1'b0;
      frame_tick = 1'b0;
      bU = 0; bD = 0; bL = 0; bR = 0; bC = 0;

      // Reset values while held low
      waitClocks(3);
      checkOutput("rst_x", int'(boxX), 304);
      checkOutput("rst_y", int'(boxY), 224);
      checkOutput("rst_color", int'(colorSel), 0);
      checkOutput("rst_edge", int'(atEdge), 0);
      reset = 1'b1;
      waitClocks(2);

      // Idle frames leave everything alone
      for (int k = 1; k <= 5; k++) begin
         frameTick();
         checkOutput($sformatf("idle_x%0d", k), int'(boxX), 304);
         checkOutput($sformatf("idle_y%0d", k), int'(boxY), 224);
         checkOutput($sformatf("idle_c%0d", k), int'(colorSel), 0);
         checkOutput($sformatf("idle_e%0d", k), int'(atEdge), 0);
      end

      // Hold right for 30 ticks: steps on ticks 1, 21, 25, 29
      applyStimulus(0, 0, 0, 1, 0);
      waitClocks(4);
      for (int k = 1; k <= 30; k++) begin
         frameTick();
         if (k < 21)      expX = 312;
         else if (k < 25) expX = 320;
         else if (k < 29) expX = 328;
         else             expX = 336;
         checkOutput($sformatf("holdR_t%0d", k), int'(boxX), expX);
      end
      applyStimulus(0, 0, 0, 0, 0);
      waitClocks(4);
      for (int k = 1; k <= 5; k++) begin
         frameTick();
         checkOutput($sformatf("relR_t%0d", k), int'(boxX), 336);
      end

      // Tap left 40 times from X_INIT, clamping at zero
      applyReset();
      for (int k = 1; k <= 40; k++) begin
         applyStimulus(0, 0, 1, 0, 0);
         waitClocks(4);
         frameTick();
         applyStimulus(0, 0, 0, 0, 0);
         waitClocks(4);
         expX = (304 - 8 * k < 0) ? 0 : 304 - 8 * k;
         checkOutput($sformatf("tapL_x%0d", k), int'(boxX), expX);
         checkOutput($sformatf("tapL_e%0d", k), int'(atEdge), (expX == 0) ? 1 : 0);
      end

      // Tap down 30 times from Y_INIT, clamping at 448
      applyReset();
      for (int k = 1; k <= 30; k++) begin
         applyStimulus(0, 1, 0, 0, 0);
         waitClocks(4);
         frameTick();
         applyStimulus(0, 0, 0, 0, 0);
         waitClocks(4);
         expY = (224 + 8 * k > 448) ? 448 : 224 + 8 * k;
         checkOutput($sformatf("tapD_y%0d", k), int'(boxY), expY);
         checkOutput($sformatf("tapD_e%0d", k), int'(atEdge), (expY == 448) ? 1 : 0);
      end

      // Up+Down cancel the vertical axis while Right still moves
      applyReset();
      applyStimulus(1, 1, 0, 1, 0);
      waitClocks(4);
      frameTick();
      checkOutput("cancel_y", int'(boxY), 224);
      checkOutput("cancel_x", int'(boxX), 312);
      applyStimulus(0, 0, 0, 0, 0);
      waitClocks(4);

      // Diagonal up-left moves both axes in one step
      applyStimulus(1, 0, 1, 0, 0);
      waitClocks(4);
      frameTick();
      checkOutput("diag_x", int'(boxX), 304);
      checkOutput("diag_y", int'(boxY), 216);
      applyStimulus(0, 0, 0, 0, 0);
      waitClocks(4);

      // Centre held across ticks gives a single increment, then wraps
      applyStimulus(0, 0, 0, 0, 1);
      waitClocks(4);
      for (int k = 0; k < 3; k++) frameTick();
      checkOutput("color_hold", int'(colorSel), 1);
      applyStimulus(0, 0, 0, 0, 0);
      waitClocks(4);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(0, 0, 0, 0, 1);
         waitClocks(4);
         applyStimulus(0, 0, 0, 0, 0);
         waitClocks(4);
         expC = (1 + k) % 8;
         checkOutput($sformatf("color_p%0d", k), int'(colorSel), expC);
      end

      // Reset mid-hold of Down, then the held button acts as a new press
      applyReset();
      applyStimulus(0, 1, 0, 0, 0);
      waitClocks(4);
      frameTick();
      checkOutput("rsth_first", int'(boxY), 232);
      for (int k = 0; k < 10; k++) frameTick();
      checkOutput("rsth_delay", int'(boxY), 232);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("rsth_async_y", int'(boxY), 224);
      checkOutput("rsth_async_c", int'(colorSel), 0);
      waitClocks(3);
      reset = 1'b1;
      checkOutput("rsth_rel_y", int'(boxY), 224);
      waitClocks(4);
      frameTick();
      checkOutput("rsth_step1", int'(boxY), 232);
      for (int k = 1; k <= 19; k++) frameTick();
      checkOutput("rsth_t19", int'(boxY), 232);
      frameTick();
      checkOutput("rsth_t20", int'(boxY), 240);
      applyStimulus(0, 0, 0, 0, 0);
      waitClocks(4);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
